// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - pipeline write-back stage: result select, load formatting, register-file write port
module wb_unit #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_pc_plus4,
    input  logic [RA_W-1:0] in_rd,
    input  logic            in_reg_write,
    input  logic [1:0]      in_wb_sel,
    input  logic [2:0]      in_load_funct3,
    input  logic [1:0]      in_addr_lo,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     wb_count,
    output logic            rsp_err
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_MEM = 1'b1;

    logic [0:0]      state;
    logic [RA_W-1:0] pend_rd;
    logic [2:0]      pend_funct3;
    logic [1:0]      pend_addr_lo;
    logic [31:0]     count_q;

    logic            accept;
    logic            is_load;
    logic [XLEN-1:0] direct_data;
    logic [XLEN-1:0] load_data;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    // Reset forces ready high so the upstream stage never sees a stall during reset,
    // but nothing is accepted while reset is asserted.
    assign in_ready = (state == IDLE) | rst;
    assign accept   = in_valid & in_ready & ~rst;
    assign is_load  = (in_wb_sel == 2'b01) & in_reg_write;
    assign wb_count = count_q;

    always_comb begin
        direct_data = in_alu_result;
        if (in_wb_sel == 2'b10) begin
            direct_data = in_pc_plus4;
        end
    end

    assign byte_sel = mem_rsp_data[{pend_addr_lo, 3'b000} +: 8];
    assign half_sel = pend_addr_lo[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];

    always_comb begin
        load_data = mem_rsp_data;
        case (pend_funct3)
            3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = mem_rsp_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            count_q      <= '0;
            rsp_err      <= 1'b0;
            pend_rd      <= '0;
            pend_funct3  <= '0;
            pend_addr_lo <= '0;
        end else begin
            rf_we <= 1'b0;
            if (state == IDLE) begin
                if (mem_rsp_valid) begin
                    rsp_err <= 1'b1;
                end
                if (accept) begin
                    if (is_load) begin
                        pend_rd      <= in_rd;
                        pend_funct3  <= in_load_funct3;
                        pend_addr_lo <= in_addr_lo;
                        state        <= WAIT_MEM;
                    end else begin
                        rf_we    <= in_reg_write & (in_rd != '0);
                        rf_waddr <= in_rd;
                        rf_wdata <= direct_data;
                        count_q  <= count_q + 32'd1;
                    end
                end
            end else if (mem_rsp_valid) begin
                rf_we    <= (pend_rd != '0);
                rf_waddr <= pend_rd;
                rf_wdata <= load_data;
                count_q  <= count_q + 32'd1;
                state    <= IDLE;
            end
        end
    end

endmodule
